// File: rtl/s2p_receiver.sv
// rtl/s2p_receiver.sv - nibble-serial to 32-bit parallel receiver (optional parity via S2P_PARITY_EN)
module s2p_receiver (
  input  logic       CLK,
  input  logic       reset,
  input  logic       ENB,
  input  logic       frame_start,
  input  logic [3:0] data_in,
  output logic [7:0] D3,
  output logic [7:0] D2,
  output logic [7:0] D1,
  output logic [7:0] D0,
  output logic       valid,
  output logic [2:0] sel,
  output logic       busy,
  output logic       frame_err,
  output logic       err_par
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;

  // Without parity the eighth nibble is appended straight into the output
  // word, so only seven nibbles (28 bits) ever need to sit in the shifter.
`ifdef S2P_PARITY_EN
  localparam int SHIFT_W = 32;
`else
  localparam int SHIFT_W = 28;
`endif

  state_t               r_state;
  state_t               w_next_state;
  logic [SHIFT_W-1:0]   r_shift;
  logic [2:0]           r_sel;
  logic [31:0]          r_word;
  logic                 r_valid;
  logic                 r_frame_err;
`ifdef S2P_PARITY_EN
  logic [3:0]           r_par;
  logic                 r_err_par;
`endif

  logic                 w_start;
  logic                 w_final;
  logic                 w_abort;
  logic                 w_shift;

  // State register
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; a frame_start on the completing nibble is not an abort
  always_comb begin
    w_next_state = r_state;
    if (ENB) begin
      case (r_state)
        ST_IDLE: begin
          if (frame_start) w_next_state = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (frame_start && !w_final) begin
            w_next_state = ST_SHIFT;
          end else if (r_sel == 3'd7) begin
`ifdef S2P_PARITY_EN
            w_next_state = ST_PAR;
`else
            w_next_state = ST_IDLE;
`endif
          end
        end
        ST_PAR:  w_next_state = ST_IDLE;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // Control decode: which datapath action this enabled cycle performs
  always_comb begin
    w_start = ENB && (r_state == ST_IDLE) && frame_start;
`ifdef S2P_PARITY_EN
    w_final = ENB && (r_state == ST_PAR);
`else
    w_final = ENB && (r_state == ST_SHIFT) && (r_sel == 3'd7);
`endif
    w_abort = ENB && frame_start && (r_state != ST_IDLE) && !w_final;
    w_shift = ENB && (r_state == ST_SHIFT) && !w_abort;
  end

  // Datapath: shifter, nibble index, output word and one-cycle strobes
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_shift     <= '0;
      r_sel       <= 3'd0;
      r_word      <= 32'd0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef S2P_PARITY_EN
      r_par       <= 4'd0;
      r_err_par   <= 1'b0;
`endif
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_start || w_abort) begin
        // The current nibble is nibble 0 of a fresh frame either way
        r_shift     <= {{(SHIFT_W-4){1'b0}}, data_in};
        r_sel       <= 3'd1;
        r_frame_err <= w_abort;
`ifdef S2P_PARITY_EN
        r_par       <= data_in;
`endif
      end else if (w_shift) begin
        r_shift <= {r_shift[SHIFT_W-5:0], data_in};
        r_sel   <= r_sel + 3'd1;
`ifdef S2P_PARITY_EN
        r_par   <= r_par ^ data_in;
`else
        if (w_final) begin
          r_word  <= {r_shift, data_in};
          r_valid <= 1'b1;
        end
`endif
      end
`ifdef S2P_PARITY_EN
      else if (w_final) begin
        r_word    <= r_shift;
        r_valid   <= 1'b1;
        r_err_par <= (data_in != r_par);
      end
`endif
    end
  end

  assign D3        = r_word[31:24];
  assign D2        = r_word[23:16];
  assign D1        = r_word[15:8];
  assign D0        = r_word[7:0];
  assign valid     = r_valid;
  assign sel       = r_sel;
  assign busy      = (r_state != ST_IDLE);
  assign frame_err = r_frame_err;
`ifdef S2P_PARITY_EN
  assign err_par   = r_err_par;
`else
  assign err_par   = 1'b0;
`endif

endmodule

// File: tb/tb_s2p_receiver.sv
// tb/tb_s2p_receiver.sv - self-checking bench for s2p_receiver (default build)
module tb_s2p_receiver;

  logic       CLK = 1'b0;
  logic       reset;
  logic       ENB;
  logic       frame_start;
  logic [3:0] data_in;
  logic [7:0] D3, D2, D1, D0;
  logic       valid;
  logic [2:0] sel;
  logic       busy;
  logic       frame_err;
  logic       err_par;
  logic [31:0] dout;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: the nibbles collected so far in the open frame
  int          m_nibs[$];
  logic [31:0] m_word;
  bit          m_valid;
  bit          m_ferr;

  always #5 CLK = ~CLK;

  assign dout = {D3, D2, D1, D0};

  s2p_receiver dut (
    .CLK         (CLK),
    .reset       (reset),
    .ENB         (ENB),
    .frame_start (frame_start),
    .data_in     (data_in),
    .D3          (D3),
    .D2          (D2),
    .D1          (D1),
    .D0          (D0),
    .valid       (valid),
    .sel         (sel),
    .busy        (busy),
    .frame_err   (frame_err),
    .err_par     (err_par)
  );

  task automatic model_update(input bit rst, input bit enb, input bit fs, input logic [3:0] nib);
    m_valid = 0;
    m_ferr  = 0;
    if (rst) begin
      m_nibs.delete();
      m_word = 32'd0;
    end else if (enb) begin
      if (m_nibs.size() > 0 && fs && m_nibs.size() != 7) begin
        m_ferr = 1;
        m_nibs.delete();
        m_nibs.push_back(int'(nib));
      end else if (m_nibs.size() > 0 || fs) begin
        m_nibs.push_back(int'(nib));
        if (m_nibs.size() == 8) begin
          m_word = 32'd0;
          foreach (m_nibs[i]) m_word = m_word * 16 + 32'(m_nibs[i]);
          m_valid = 1;
          m_nibs.delete();
        end
      end
    end
  endtask

  task automatic step(input bit rst, input bit enb, input bit fs, input logic [3:0] nib);
    @(negedge CLK);
    reset       = rst;
    ENB         = enb;
    frame_start = fs;
    data_in     = nib;
    @(posedge CLK);
    model_update(rst, enb, fs, nib);
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 1, 4'hF);
    step(1, 0, 0, 4'h0);
    n_total++; if (dout !== 32'd0) $display("FAIL reset_d got %h want 00000000", dout); else n_pass++;
    n_total++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else n_pass++;
    n_total++; if (sel !== 3'd0) $display("FAIL reset_sel got %0d want 0", sel); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_total++; if (frame_err !== 1'b0) $display("FAIL reset_ferr got %b want 0", frame_err); else n_pass++;
    n_total++; if (err_par !== 1'b0) $display("FAIL reset_errpar got %b want 0", err_par); else n_pass++;
  endtask

  task automatic test_single_frame();
    logic [31:0] w;
    w = 32'h01234567;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, (i == 0), w[31-4*i -: 4]);
      if (i == 0) begin
        n_total++; if (sel !== 3'd1) $display("FAIL single_sel0 got %0d want 1", sel); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL single_busy0 got %b want 1", busy); else n_pass++;
      end
      if (i < 7) begin
        n_total++; if (valid !== 1'b0) $display("FAIL single_early_valid step %0d got %b want 0", i, valid); else n_pass++;
      end
    end
    n_total++; if (dout !== 32'h01234567) $display("FAIL single_word got %h want 01234567", dout); else n_pass++;
    n_total++; if (valid !== 1'b1) $display("FAIL single_valid got %b want 1", valid); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL single_busy got %b want 0", busy); else n_pass++;
    n_total++; if (sel !== 3'd0) $display("FAIL single_sel got %0d want 0", sel); else n_pass++;
    step(0, 1, 0, 4'($urandom));
    n_total++; if (valid !== 1'b0) $display("FAIL single_pulse got %b want 0", valid); else n_pass++;
    n_total++; if (dout !== 32'h01234567) $display("FAIL single_hold got %h want 01234567", dout); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    a = 32'h89ABCDEF;
    b = 32'hFEDCBA98;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) step(0, 1, (i == 0), a[31-4*i -: 4]);
      else       step(0, 1, (i == 8), b[31-4*(i-8) -: 4]);
      if (i == 7) begin
        n_total++; if (dout !== a) $display("FAIL b2b_first got %h want %h", dout, a); else n_pass++;
        n_total++; if (valid !== 1'b1) $display("FAIL b2b_first_valid got %b want 1", valid); else n_pass++;
      end else if (i >= 8 && i < 15) begin
        n_total++; if (dout !== a || valid !== 1'b0)
          $display("FAIL b2b_hold step %0d got %h/%b want %h/0", i, dout, valid, a); else n_pass++;
      end
    end
    n_total++; if (dout !== b) $display("FAIL b2b_second got %h want %h", dout, b); else n_pass++;
    n_total++; if (valid !== 1'b1) $display("FAIL b2b_second_valid got %b want 1", valid); else n_pass++;
  endtask

  task automatic test_enb_stall();
    logic [31:0] w;
    w = 32'hAAAAAAAA;
    for (int i = 0; i < 4; i++) step(0, 1, (i == 0), w[31-4*i -: 4]);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 1'($urandom), 4'($urandom));
      n_total++; if (sel !== 3'd4 || busy !== 1'b1 || valid !== 1'b0)
        $display("FAIL stall_hold k %0d got sel %0d busy %b valid %b want 4/1/0", k, sel, busy, valid); else n_pass++;
    end
    for (int i = 4; i < 8; i++) begin
      step(0, 1, 0, w[31-4*i -: 4]);
      if (i < 7) begin
        n_total++; if (valid !== 1'b0) $display("FAIL stall_early_valid step %0d got %b want 0", i, valid); else n_pass++;
      end
    end
    n_total++; if (dout !== w || valid !== 1'b1)
      $display("FAIL stall_word got %h/%b want %h/1", dout, valid, w); else n_pass++;
  endtask

  task automatic test_abort();
    logic [31:0] a, b, prev;
    int ferr_cnt;
    a = 32'h55555555;
    b = 32'h81A3C5E7;
    step(0, 1, 0, 4'h0);
    prev = dout;
    ferr_cnt = 0;
    for (int i = 0; i < 4; i++) step(0, 1, (i == 0), a[31-4*i -: 4]);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, (i == 0), b[31-4*i -: 4]);
      if (frame_err === 1'b1) ferr_cnt++;
      if (i == 0) begin
        n_total++; if (frame_err !== 1'b1 || sel !== 3'd1)
          $display("FAIL abort_pulse got ferr %b sel %0d want 1/1", frame_err, sel); else n_pass++;
      end
      if (i < 7) begin
        n_total++; if (valid !== 1'b0 || dout !== prev)
          $display("FAIL abort_hold step %0d got %h/%b want %h/0", i, dout, valid, prev); else n_pass++;
      end
    end
    n_total++; if (ferr_cnt != 1) $display("FAIL abort_count got %0d want 1", ferr_cnt); else n_pass++;
    n_total++; if (dout !== b || valid !== 1'b1)
      $display("FAIL abort_restart got %h/%b want %h/1", dout, valid, b); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b;
    a = 32'h13579BDF;
    b = 32'h092B4D6F;
    for (int i = 0; i < 6; i++) step(0, 1, (i == 0), a[31-4*i -: 4]);
    step(1, 1, 1, 4'hC);
    n_total++; if ({dout, valid, sel, busy, frame_err, err_par} !== 45'd0)
      $display("FAIL midreset got d %h v %b sel %0d busy %b ferr %b ep %b want all 0",
               dout, valid, sel, busy, frame_err, err_par); else n_pass++;
    for (int i = 0; i < 8; i++) step(0, 1, (i == 0), b[31-4*i -: 4]);
    n_total++; if (dout !== b || valid !== 1'b1)
      $display("FAIL midreset_next got %h/%b want %h/1", dout, valid, b); else n_pass++;
  endtask

  task automatic test_random();
    bit rst, enb, fs;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      enb = ($urandom_range(0, 9) != 0);
      fs  = ($urandom_range(0, 6) == 0);
      step(rst, enb, fs, 4'($urandom));
      n_total++; if (dout !== m_word) $display("FAIL rand_word c %0d got %h want %h", c, dout, m_word); else n_pass++;
      n_total++; if (valid !== m_valid) $display("FAIL rand_valid c %0d got %b want %b", c, valid, m_valid); else n_pass++;
      n_total++; if (frame_err !== m_ferr) $display("FAIL rand_ferr c %0d got %b want %b", c, frame_err, m_ferr); else n_pass++;
      n_total++; if (sel !== 3'(m_nibs.size())) $display("FAIL rand_sel c %0d got %0d want %0d", c, sel, m_nibs.size()); else n_pass++;
      n_total++; if (busy !== (m_nibs.size() > 0)) $display("FAIL rand_busy c %0d got %b want %b", c, busy, (m_nibs.size() > 0)); else n_pass++;
      n_total++; if (err_par !== 1'b0) $display("FAIL rand_errpar c %0d got %b want 0", c, err_par); else n_pass++;
    end
  endtask

  initial begin
    reset       = 1'b1;
    ENB         = 1'b0;
    frame_start = 1'b0;
    data_in     = 4'h0;
    m_word      = 32'd0;
    m_valid     = 0;
    m_ferr      = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_enb_stall();
    test_abort();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/s2p_receiver.md
# s2p_receiver

Serial-to-parallel receiver: the receive end of the 4-bit nibble link driven by the p2s serializer. Reassembles eight consecutive 4-bit nibbles (MSB nibble first) into one 32-bit word. Presents the word as four byte lanes D3..D0 with a one-cycle `valid` strobe. Sits at the link input, feeding the 4×8-bit lane logic.

## Interface
Parameters:
- none. Frame length is fixed at 8 data nibbles; optional parity is controlled by the macro in Configuration.

Ports:
- `CLK` in 1: single clock. All logic is rising-edge.
- `reset` in 1: synchronous, active-high reset.
- `ENB` in 1: enable. When low, the block freezes completely.
- `frame_start` in 1: marks the first nibble of a frame. It is sampled in the same cycle as that nibble.
- `data_in` in 4: received nibble.
- `D3`, `D2`, `D1`, `D0` out 8 each: word bytes. D3 = word[31:24], D0 = word[7:0].
- `valid` out 1: one-cycle pulse when D3..D0 are updated.
- `sel` out 3: index of the next nibble expected within the frame.
- `busy` out 1: high while a frame is in progress.
- `frame_err` out 1: one-cycle pulse when a frame is aborted by a premature `frame_start`.
- `err_par` out 1: parity error flag, qualified by `valid`.

## Operation
- Reset values: D3..D0 = 0x00, `valid` = 0, `sel` = 0, `busy` = 0, `frame_err` = 0, `err_par` = 0. The state machine returns to IDLE and the shift register is cleared.
- States are IDLE, SHIFT and, only with the macro, PAR.
- IDLE:
  - With `ENB`=1 and `frame_start`=1, shift in `data_in`, set `sel`=1, go to SHIFT.
  - Otherwise, `data_in` is ignored.
- SHIFT:
  - Each enabled cycle shifts in `data_in` (word = {word[27:0], data_in}) and increments `sel`.
  - When the nibble with `sel`=7 is accepted:
    - Without the macro: load D3..D0, pulse `valid`, go to IDLE.
    - With the macro: go to PAR.
  - `sel` wraps 7→0.
- PAR (macro only): the nibble is compared with the running XOR of the 8 data nibbles. Load D3..D0, pulse `valid`, set `err_par` = (mismatch), go to IDLE.
- `frame_start`=1 while in SHIFT or PAR aborts the current frame:
  - `frame_err` pulses on the next cycle.
  - The current nibble becomes nibble 0 of a new frame (`sel`=1, state SHIFT).
  - D3..D0 stay unchanged and `valid` is not asserted.
- `frame_start` in the same cycle that the last nibble of a frame is accepted is not an abort. It is treated like the case below.
- `frame_start` in the cycle right after the last nibble (back-to-back frames) is legal. The new frame starts in IDLE and the previous `valid` is unaffected.
- `ENB`=0:
  - State, `sel`, the shift register and D3..D0 hold.
  - `data_in` and `frame_start` are ignored.
  - `valid` and `frame_err` are forced to 0.
  - A frame resumes where it stopped once `ENB` returns high.
- `reset` has priority over `ENB` and all other inputs. Reset mid-frame discards the partial word.
- D3..D0 hold the last completed word until the next completed frame.
- `busy` = 1 in SHIFT and PAR.
- `err_par` holds until the next `valid` or `reset`.

## Timing
- Frame start: nibble 0 arrives with `frame_start` in cycle t. Nibbles 1..7 arrive in cycles t+1..t+7, with `ENB` high throughout.
- Without the macro: D3..D0 and `valid` are registered and visible in cycle t+8. Latency from the last nibble to the output is 1 cycle.
- With the macro: the parity nibble arrives in t+8, and `valid`/`err_par` are visible in t+9.
- Each cycle with `ENB`=0 during a frame delays completion by one cycle.
- Throughput is one word per 8 cycles, or per 9 cycles with the macro.
- All outputs are registered, with no combinational path from any input to any output.

## Configuration
- `S2P_PARITY_EN` defined:
  - Frames carry a 9th nibble equal to the bitwise XOR of the 8 data nibbles.
  - The PAR state exists and `err_par` is computed.
- Not defined:
  - The frame is 8 nibbles, no PAR state exists, and `err_par` is tied to 0.

## Test plan
- Reset, then `ENB`=1 and frame 0x01234567 (nibbles 0,1,…,7 from t): cycle t+8 has D3=0x01, D2=0x23, D1=0x45, D0=0x67, `valid`=1 for exactly one cycle, `busy`=0.
- Back-to-back frames 0x89ABCDEF then 0xFEDCBA98 with `frame_start` in t and t+8: `valid` at t+8 with 0x89ABCDEF and at t+16 with 0xFEDCBA98, and D3..D0 hold between the two.
- Frame 0xAAAAAAAA with `ENB`=0 for 3 cycles after nibble 3: `sel` holds at 4, `valid` at t+11, word 0xAAAAAAAA.
- Frame 0x55555555 with `frame_start` reasserted at nibble 4, followed by 0x81A3C5E7: `frame_err` pulses once, the aborted word is never output, and 0x81A3C5E7 appears 8 cycles after the restart.
- `reset` high mid-frame (after nibble 5): all outputs return to their reset values next cycle, and a following frame 0x092B4D6F completes normally.
- With `S2P_PARITY_EN`:
  - 0xFFFFFFFF plus parity nibble 0x0 gives `valid`=1, `err_par`=0.
  - 0xFFFFFFFF plus parity nibble 0x1 gives `valid`=1, `err_par`=1, D = 0xFFFFFFFF.
